line_raster: RTL and testbench

Parametrised Bresenham line rasteriser: accepts one line segment (two endpoints) per handshake and emits every pixel on it as a valid/ready stream, one pixel per cycle at full throughput. Sits between the projection/transform stage that produces `line_t` segments and the frame/pixel compositor. It generalises the fixed 7-bit line datapath to any coordinate width. It adds backpressure, polyline endpoint suppression and synchronous flush.

---
 rtl/types.sv | 23 ++
 rtl/raster_step.sv | 52 +++++
 rtl/line_raster.sv | 191 +++++++++++++++++++
 tb/tb_line_raster.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/types.sv
// Shared types for the line rasteriser.
//   LINE_BITS      : coordinate width of the legacy fixed line datapath
//   line_t         : one segment as produced by the transform stage
//   raster_state_t : controller states of line_raster
package types;

  localparam int LINE_BITS = 7;

  typedef struct packed {
    logic [LINE_BITS-1:0] x0;
    logic [LINE_BITS-1:0] y0;
    logic [LINE_BITS-1:0] x1;
    logic [LINE_BITS-1:0] y1;
  } line_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETUP     = 2'd1,
    STEP      = 2'd2,
    UNDEFINED = 'x
  } raster_state_t;

endpackage

// File: rtl/raster_step.sv
// One combinational Bresenham step.
//   x_i, y_i       : current point
//   err_i          : current error accumulator (signed)
//   dx_i, dy_i     : |x1-x0| and -|y1-y0| (signed)
//   sx_neg_i       : 1 when x walks downwards, 0 when upwards
//   sy_neg_i       : 1 when y walks downwards, 0 when upwards
//   x_o, y_o, err_o: point and error after the step
module raster_step #(
  parameter int COORD_BITS = types::LINE_BITS,
  parameter int ERR_BITS   = COORD_BITS + 2
) (
  input  logic [COORD_BITS-1:0]      x_i,
  input  logic [COORD_BITS-1:0]      y_i,
  input  logic signed [ERR_BITS-1:0] err_i,
  input  logic signed [ERR_BITS-1:0] dx_i,
  input  logic signed [ERR_BITS-1:0] dy_i,
  input  logic                       sx_neg_i,
  input  logic                       sy_neg_i,
  output logic [COORD_BITS-1:0]      x_o,
  output logic [COORD_BITS-1:0]      y_o,
  output logic signed [ERR_BITS-1:0] err_o
);

  logic signed [ERR_BITS:0] e2;
  logic signed [ERR_BITS:0] dx_ext;
  logic signed [ERR_BITS:0] dy_ext;
  logic                     step_x;
  logic                     step_y;

  always_comb begin
    // Doubling in one extra bit so 2*err can never overflow.
    e2     = {err_i, 1'b0};
    dx_ext = {dx_i[ERR_BITS-1], dx_i};
    dy_ext = {dy_i[ERR_BITS-1], dy_i};
    step_x = (e2 >= dy_ext);
    step_y = (e2 <= dx_ext);

    err_o = err_i;
    x_o   = x_i;
    y_o   = y_i;
    // Both axes may advance in the same step (diagonal move).
    if (step_x) begin
      err_o = err_o + dy_i;
      x_o   = sx_neg_i ? (x_i - COORD_BITS'(1)) : (x_i + COORD_BITS'(1));
    end
    if (step_y) begin
      err_o = err_o + dx_i;
      y_o   = sy_neg_i ? (y_i - COORD_BITS'(1)) : (y_i + COORD_BITS'(1));
    end
  end

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser: one segment per handshake, one pixel per cycle.
//   clk_i, rst_ni          : clock, async active-low reset
//   line_valid_i/ready_o   : segment handshake (ready only in IDLE)
//   x0_i..y1_i             : segment endpoints
//   omit_last_i            : drop the end pixel (polyline chaining)
//   px_valid_o/px_ready_i  : pixel stream handshake
//   px_x_o, px_y_o         : pixel coordinate
//   px_last_o              : final emitted pixel of the segment
//   done_o                 : one-cycle pulse after a segment completes
//   flush_i                : synchronous abort to IDLE
//   busy_o                 : controller not IDLE
module line_raster
  import types::*;
#(
  parameter int COORD_BITS = LINE_BITS,
  parameter int ERR_BITS   = COORD_BITS + 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  line_valid_i,
  output logic                  line_ready_o,
  input  logic [COORD_BITS-1:0] x0_i,
  input  logic [COORD_BITS-1:0] y0_i,
  input  logic [COORD_BITS-1:0] x1_i,
  input  logic [COORD_BITS-1:0] y1_i,
  input  logic                  omit_last_i,
  output logic                  px_valid_o,
  input  logic                  px_ready_i,
  output logic [COORD_BITS-1:0] px_x_o,
  output logic [COORD_BITS-1:0] px_y_o,
  output logic                  px_last_o,
  output logic                  done_o,
  input  logic                  flush_i,
  output logic                  busy_o
);

  raster_state_t state_q, state_d;

  logic [COORD_BITS-1:0]      x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COORD_BITS-1:0]      x_q, x_d, y_q, y_d;
  logic                       omit_q, omit_d;
  logic signed [ERR_BITS-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic                       sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic                       valid_q, valid_d, last_q, last_d, done_q, done_d;

  // Setup-time values derived from the registered endpoints.
  logic [COORD_BITS-1:0]      ax_c, ay_c;
  logic signed [ERR_BITS-1:0] dx_c, dy_c, err0_c;
  logic                       sx_neg_c, sy_neg_c, single_c;

  always_comb begin
    ax_c     = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    ay_c     = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    dx_c     = ERR_BITS'(ax_c);
    dy_c     = '0 - ERR_BITS'(ay_c);
    err0_c   = dx_c + dy_c;
    sx_neg_c = !(x0_q < x1_q);
    sy_neg_c = !(y0_q < y1_q);
    single_c = (x0_q == x1_q) && (y0_q == y1_q);
  end

  // Step A advances the current point. Step B looks one point further ahead
  // of whatever is about to be loaded, so px_last can be registered together
  // with the point itself (needed for omit_last, which flags the point whose
  // successor is the end point).
  logic [COORD_BITS-1:0]      a_x, a_y, b_x_in, b_y_in, b_x, b_y;
  logic signed [ERR_BITS-1:0] a_err, b_err_in, b_err_unused;
  logic signed [ERR_BITS-1:0] use_dx, use_dy;
  logic                       use_sx, use_sy, in_setup, last_c;

  raster_step #(.COORD_BITS(COORD_BITS), .ERR_BITS(ERR_BITS)) u_step_a (
    .x_i(x_q), .y_i(y_q), .err_i(err_q), .dx_i(dx_q), .dy_i(dy_q),
    .sx_neg_i(sx_neg_q), .sy_neg_i(sy_neg_q),
    .x_o(a_x), .y_o(a_y), .err_o(a_err)
  );

  always_comb begin
    in_setup = (state_q == SETUP);
    use_dx   = in_setup ? dx_c     : dx_q;
    use_dy   = in_setup ? dy_c     : dy_q;
    use_sx   = in_setup ? sx_neg_c : sx_neg_q;
    use_sy   = in_setup ? sy_neg_c : sy_neg_q;
    b_x_in   = in_setup ? x0_q     : a_x;
    b_y_in   = in_setup ? y0_q     : a_y;
    b_err_in = in_setup ? err0_c   : a_err;
  end

  raster_step #(.COORD_BITS(COORD_BITS), .ERR_BITS(ERR_BITS)) u_step_b (
    .x_i(b_x_in), .y_i(b_y_in), .err_i(b_err_in), .dx_i(use_dx), .dy_i(use_dy),
    .sx_neg_i(use_sx), .sy_neg_i(use_sy),
    .x_o(b_x), .y_o(b_y), .err_o(b_err_unused)
  );

  assign last_c = omit_q ? ((b_x == x1_q) && (b_y == y1_q))
                         : ((b_x_in == x1_q) && (b_y_in == y1_q));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (line_valid_i) state_d = SETUP;
      SETUP:   state_d = (omit_q && single_c) ? IDLE : STEP;
      STEP:    if (valid_q && px_ready_i && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Datapath / output logic
  always_comb begin
    x0_d = x0_q;  y0_d = y0_q;  x1_d = x1_q;  y1_d = y1_q;
    omit_d = omit_q;
    dx_d = dx_q;  dy_d = dy_q;  err_d = err_q;
    sx_neg_d = sx_neg_q;  sy_neg_d = sy_neg_q;
    x_d = x_q;  y_d = y_q;
    valid_d = valid_q;  last_d = last_q;  done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (line_valid_i) begin
          x0_d = x0_i;  y0_d = y0_i;  x1_d = x1_i;  y1_d = y1_i;
          omit_d = omit_last_i;
        end
      end
      SETUP: begin
        dx_d = dx_c;  dy_d = dy_c;  err_d = err0_c;
        sx_neg_d = sx_neg_c;  sy_neg_d = sy_neg_c;
        x_d = x0_q;  y_d = y0_q;
        if (omit_q && single_c) begin
          done_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          last_d  = last_c;
        end
      end
      STEP: begin
        if (valid_q && px_ready_i) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_d = a_x;  y_d = a_y;  err_d = a_err;
            last_d = last_c;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
    if (flush_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x0_q <= '0;  y0_q <= '0;  x1_q <= '0;  y1_q <= '0;
      omit_q <= 1'b0;
      dx_q <= '0;  dy_q <= '0;  err_q <= '0;
      sx_neg_q <= 1'b0;  sy_neg_q <= 1'b0;
      x_q <= '0;  y_q <= '0;
      valid_q <= 1'b0;  last_q <= 1'b0;  done_q <= 1'b0;
    end else begin
      x0_q <= x0_d;  y0_q <= y0_d;  x1_q <= x1_d;  y1_q <= y1_d;
      omit_q <= omit_d;
      dx_q <= dx_d;  dy_q <= dy_d;  err_q <= err_d;
      sx_neg_q <= sx_neg_d;  sy_neg_q <= sy_neg_d;
      x_q <= x_d;  y_q <= y_d;
      valid_q <= valid_d;  last_q <= last_d;  done_q <= done_d;
    end
  end

  assign line_ready_o = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign px_valid_o   = valid_q;
  assign px_x_o       = x_q;
  assign px_y_o       = y_q;
  assign px_last_o    = last_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_line_raster.sv
module tb_line_raster;

  localparam int CB = 7;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          line_valid_i = 1'b0;
  logic          line_ready_o;
  logic [CB-1:0] x0_i = '0, y0_i = '0, x1_i = '0, y1_i = '0;
  logic          omit_last_i = 1'b0;
  logic          px_valid_o;
  logic          px_ready_i = 1'b1;
  logic [CB-1:0] px_x_o, px_y_o;
  logic          px_last_o;
  logic          done_o;
  logic          flush_i = 1'b0;
  logic          busy_o;

  line_raster #(.COORD_BITS(CB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .line_valid_i(line_valid_i), .line_ready_o(line_ready_o),
    .x0_i(x0_i), .y0_i(y0_i), .x1_i(x1_i), .y1_i(y1_i),
    .omit_last_i(omit_last_i),
    .px_valid_o(px_valid_o), .px_ready_i(px_ready_i),
    .px_x_o(px_x_o), .px_y_o(px_y_o), .px_last_o(px_last_o),
    .done_o(done_o), .flush_i(flush_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [CB-1:0] x;
    logic [CB-1:0] y;
    logic          last;
  } px_t;

  px_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  exp_done = 0;
  int  accept_cyc = 0;
  bit  want_latency = 1'b0;
  int  last_hs_cyc = -1;
  bit  stall_prev = 1'b0;
  px_t hold;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_px(input int x, input int y, input bit last);
    px_t e;
    e.x = CB'(x);
    e.y = CB'(y);
    e.last = last;
    sb_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every pixel handshake.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (px_valid_o && !px_ready_i) begin
        if (stall_prev) begin
          check("stall_hold_x", int'(px_x_o), int'(hold.x));
          check("stall_hold_y", int'(px_y_o), int'(hold.y));
          check("stall_hold_last", int'(px_last_o), int'(hold.last));
        end
        stall_prev = 1'b1;
        hold = '{x: px_x_o, y: px_y_o, last: px_last_o};
      end else begin
        stall_prev = 1'b0;
      end
      if (px_valid_o && want_latency) begin
        check("first_px_latency", cyc - accept_cyc, 2);
        want_latency = 1'b0;
      end
      if (px_valid_o && px_ready_i && !flush_i) begin
        if (sb_q.size() == 0) begin
          check("unexpected_px_x", int'(px_x_o), -1);
        end else begin
          px_t e;
          e = sb_q.pop_front();
          check("px_x", int'(px_x_o), int'(e.x));
          check("px_y", int'(px_y_o), int'(e.y));
          check("px_last", int'(px_last_o), int'(e.last));
          $display("pixel (%0d,%0d) last=%0d", px_x_o, px_y_o, px_last_o);
          if (px_last_o) last_hs_cyc = cyc;
        end
      end
      if (done_o) begin
        done_cnt++;
        if (last_hs_cyc >= 0) begin
          check("done_timing", cyc, last_hs_cyc + 1);
          last_hs_cyc = -1;
        end
      end
    end
  end

  task automatic send(input int x0, input int y0, input int x1, input int y1,
                      input bit omit, input bit has_px);
    bit ok;
    ok = 1'b0;
    @(posedge clk_i);
    #1;
    x0_i = CB'(x0);  y0_i = CB'(y0);  x1_i = CB'(x1);  y1_i = CB'(y1);
    omit_last_i = omit;
    line_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (line_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("line_accept", int'(ok), 1);
    accept_cyc = cyc;
    want_latency = has_px;
    $display("segment (%0d,%0d)->(%0d,%0d) omit=%0d issued", x0, y0, x1, y1, omit);
    @(posedge clk_i);
    #1;
    line_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() == 0 && done_cnt >= exp_done) break;
    end
    repeat (3) @(posedge clk_i);
    #1;
    check({name, "_queue_empty"}, sb_q.size(), 0);
    check({name, "_done_count"}, done_cnt, exp_done);
    check({name, "_idle"}, int'(line_ready_o), 1);
  endtask

  task automatic wait_sb_size(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() <= n) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_sb_size", int'(ok), 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_line_ready", int'(line_ready_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_px_valid", int'(px_valid_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_px_x", int'(px_x_o), 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Basic shallow line
    push_px(0, 0, 0); push_px(1, 0, 0); push_px(2, 1, 0); push_px(3, 1, 1);
    send(0, 0, 3, 1, 1'b0, 1'b1);
    exp_done++;
    drain("basic");

    // Full-range anti-diagonal, no wrap
    for (int i = 0; i < 128; i++) push_px(127 - i, i, i == 127);
    send(127, 0, 0, 127, 1'b0, 1'b1);
    exp_done++;
    drain("diag");

    // Backpressure for 3 cycles on pixel (1,0)
    push_px(0, 0, 0); push_px(1, 0, 0); push_px(2, 1, 0); push_px(3, 1, 1);
    send(0, 0, 3, 1, 1'b0, 1'b1);
    exp_done++;
    wait_sb_size(3);
    px_ready_i = 1'b0;
    @(negedge clk_i);
    check("stall_px_x", int'(px_x_o), 1);
    check("stall_px_y", int'(px_y_o), 0);
    repeat (3) @(posedge clk_i);
    #1;
    px_ready_i = 1'b1;
    drain("stall");

    // Polyline: end pixel omitted
    push_px(2, 2, 0); push_px(3, 2, 1);
    send(2, 2, 4, 2, 1'b1, 1'b1);
    exp_done++;
    drain("omit");

    // Single point with omit: nothing emitted, done still pulses
    send(6, 6, 6, 6, 1'b1, 1'b0);
    exp_done++;
    drain("omit_single");

    // Flush during the second pixel
    push_px(0, 0, 0);
    send(0, 0, 5, 0, 1'b0, 1'b1);
    wait_sb_size(0);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_px_valid", int'(px_valid_o), 0);
    check("flush_ready", int'(line_ready_o), 1);
    check("flush_busy", int'(busy_o), 0);
    repeat (4) @(posedge clk_i);
    #1;
    check("flush_no_done", done_cnt, exp_done);

    // Vertical reversed, accepted right after the flush
    push_px(5, 5, 0); push_px(5, 4, 0); push_px(5, 3, 0); push_px(5, 2, 1);
    send(5, 5, 5, 2, 1'b0, 1'b1);
    exp_done++;
    drain("vert");

    // Asynchronous reset mid-segment
    for (int i = 0; i <= 10; i++) push_px(i, 0, i == 10);
    send(0, 0, 10, 0, 1'b0, 1'b1);
    wait_sb_size(8);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_px_valid", int'(px_valid_o), 0);
    check("arst_px_x", int'(px_x_o), 0);
    check("arst_px_last", int'(px_last_o), 0);
    check("arst_done", int'(done_o), 0);
    check("arst_busy", int'(busy_o), 0);
    check("arst_ready", int'(line_ready_o), 1);
    sb_q.delete();
    want_latency = 1'b0;
    last_hs_cyc = -1;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Recovery after reset
    push_px(0, 0, 0); push_px(1, 0, 0); push_px(2, 1, 0); push_px(3, 1, 1);
    send(0, 0, 3, 1, 1'b0, 1'b1);
    exp_done++;
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
